uart_rx: RTL

//   8N1 UART receiver. Deserialises the external rx line into bytes and hands

---
 rtl/uart_rx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint and emits one-cycle
// valid or frame-error pulses. A held-low line is parked until it returns high.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       rx,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       frame_error
);

  localparam int unsigned TIMER_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLOCKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLOCKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           index_q, index_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_d;
  logic                 valid_d;
  logic                 ferr_d;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      index_q     <= '0;
      shift_q     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      index_q     <= index_d;
      shift_q     <= shift_d;
      out_data    <= data_d;
      out_valid   <= valid_d;
      frame_error <= ferr_d;
    end
  end

  // Next-state, bit timing and output pulse generation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    index_d = index_q;
    shift_d = shift_q;
    data_d  = out_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        // Mid start bit: a line that has gone high again was only a glitch.
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
            index_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d          = '0;
          shift_d[index_q] = rx_s;
          index_d          = index_q + 3'(1);
          if (index_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is seen in idle.
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BRK;
          end
        end
      end

      S_BRK: begin
        timer_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
